// File: rtl/tmds_pkg.sv
// Shared TMDS types, control-period symbols and popcount helper.
// Imported by tmds_encoder, the HDMI transmitter and the bench.
package tmds_pkg;

  typedef logic [9:0]        tmds_sym_t;
  typedef logic signed [4:0] tmds_bal_t;

  localparam tmds_sym_t TMDS_CTRL_00 = 10'b1101010100;
  localparam tmds_sym_t TMDS_CTRL_01 = 10'b0010101011;
  localparam tmds_sym_t TMDS_CTRL_10 = 10'b0101010100;
  localparam tmds_sym_t TMDS_CTRL_11 = 10'b1010101011;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/tmds_encoder.sv
// Single-channel DVI TMDS 8b/10b encoder with running DC balance.
// Input register, transition-minimisation stage, balance stage, optional output register.
module tmds_encoder
  import tmds_pkg::*;
#(
  parameter bit OUT_REG = 1'b1
) (
  input  logic       clk_pix,
  input  logic       rst_pix,
  input  logic       de,
  input  logic [1:0] ctrl,
  input  logic [7:0] data,
  output logic [9:0] tmds
);

  logic       de_s0, de_s1;
  logic [1:0] ctrl_s0, ctrl_s1;
  logic [7:0] data_s0;
  logic [8:0] qm, qm_s1;
  logic [3:0] n1d;
  logic       use_xnor;
  logic [4:0] n1q, n0q;
  tmds_bal_t  diff, cnt, cnt_next;
  tmds_sym_t  sym_next, sym_s2;

  // Data is zeroed during blanking so an undriven bus never reaches the encoder.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      de_s0   <= 1'b0;
      ctrl_s0 <= 2'b00;
      data_s0 <= 8'h00;
    end else begin
      de_s0   <= de;
      ctrl_s0 <= de ? 2'b00 : ctrl;
      data_s0 <= de ? data : 8'h00;
    end
  end

  always_comb begin
    n1d      = popcount8(data_s0);
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !data_s0[0]);
    qm       = '0;
    qm[0]    = data_s0[0];
    for (int i = 1; i < 8; i++)
      qm[i] = use_xnor ? ~(qm[i-1] ^ data_s0[i]) : (qm[i-1] ^ data_s0[i]);
    qm[8] = ~use_xnor;
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      qm_s1   <= '0;
      de_s1   <= 1'b0;
      ctrl_s1 <= 2'b00;
    end else begin
      qm_s1   <= qm;
      de_s1   <= de_s0;
      ctrl_s1 <= ctrl_s0;
    end
  end

  always_comb begin
    n1q      = {1'b0, popcount8(qm_s1[7:0])};
    n0q      = 5'd8 - n1q;
    diff     = $signed(n1q - n0q);
    cnt_next = cnt;
    sym_next = TMDS_CTRL_00;
    if (!de_s1) begin
      cnt_next = '0;
      case (ctrl_s1)
        2'b00:   sym_next = TMDS_CTRL_00;
        2'b01:   sym_next = TMDS_CTRL_01;
        2'b10:   sym_next = TMDS_CTRL_10;
        default: sym_next = TMDS_CTRL_11;
      endcase
    end else if ((cnt == 5'sd0) || (n1q == n0q)) begin
      sym_next = {~qm_s1[8], qm_s1[8], qm_s1[8] ? qm_s1[7:0] : ~qm_s1[7:0]};
      cnt_next = qm_s1[8] ? (cnt + diff) : (cnt - diff);
    end else if (((cnt > 5'sd0) && (n1q > n0q)) || ((cnt < 5'sd0) && (n0q > n1q))) begin
      sym_next = {1'b1, qm_s1[8], ~qm_s1[7:0]};
      cnt_next = cnt + (qm_s1[8] ? 5'sd2 : 5'sd0) - diff;
    end else begin
      sym_next = {1'b0, qm_s1[8], qm_s1[7:0]};
      cnt_next = cnt + diff - (qm_s1[8] ? 5'sd0 : 5'sd2);
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      sym_s2 <= TMDS_CTRL_00;
      cnt    <= '0;
    end else begin
      sym_s2 <= sym_next;
      cnt    <= cnt_next;
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic [9:0] tmds_q;
      always_ff @(posedge clk_pix) begin
        if (rst_pix) tmds_q <= TMDS_CTRL_00;
        else         tmds_q <= sym_s2;
      end
      assign tmds = tmds_q;
    end else begin : g_no_out_reg
      assign tmds = sym_s2;
    end
  endgenerate

endmodule

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder: directed control/data cases plus
// randomized video lines checked against a behavioural encoder model.
module tb_tmds_encoder;
  import tmds_pkg::*;

  localparam bit OUT_REG = 1'b1;
  localparam int LAT     = OUT_REG ? 3 : 2;

  logic       clk_pix = 1'b0;
  logic       rst_pix = 1'b1;
  logic       de      = 1'b0;
  logic [1:0] ctrl    = 2'b00;
  logic [7:0] data    = 8'h00;
  logic [9:0] tmds;

  tmds_encoder #(.OUT_REG(OUT_REG)) dut (
    .clk_pix (clk_pix),
    .rst_pix (rst_pix),
    .de      (de),
    .ctrl    (ctrl),
    .data    (data),
    .tmds    (tmds)
  );

  always #5 clk_pix = ~clk_pix;

  typedef struct {
    logic [9:0] sym;
    bit         is_data;
    logic [7:0] d;
    bit         dir_en;
    logic [9:0] dir;
  } item_t;

  item_t q[$];
  int    mcnt;
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference encoder built from the DVI rules with plain integer arithmetic.
  task automatic model_enc(input bit de_i, input logic [1:0] c, input logic [7:0] d,
                           output logic [9:0] sym);
    int         n1, disp;
    bit         xn, q8, inv;
    logic [7:0] qv;
    if (!de_i) begin
      mcnt = 0;
      case (c)
        2'b00:   sym = 10'h354;
        2'b01:   sym = 10'h0AB;
        2'b10:   sym = 10'h154;
        default: sym = 10'h2AB;
      endcase
      return;
    end
    n1 = $countones(d);
    xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qv[0] = d[0];
    for (int i = 1; i < 8; i++) qv[i] = xn ? ~(qv[i-1] ^ d[i]) : (qv[i-1] ^ d[i]);
    q8   = !xn;
    disp = 2 * $countones(qv) - 8;
    if (mcnt == 0 || disp == 0) begin
      inv  = !q8;
      mcnt = mcnt + (q8 ? disp : -disp);
    end else if ((mcnt > 0 && disp > 0) || (mcnt < 0 && disp < 0)) begin
      inv  = 1'b1;
      mcnt = mcnt + 2 * int'(q8) - disp;
    end else begin
      inv  = 1'b0;
      mcnt = mcnt + disp - 2 * int'(!q8);
    end
    sym = {inv, q8, inv ? ~qv : qv};
  endtask

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] qq, dd;
    qq    = s[9] ? ~s[7:0] : s[7:0];
    dd[0] = qq[0];
    for (int i = 1; i < 8; i++) dd[i] = s[8] ? (qq[i] ^ qq[i-1]) : ~(qq[i] ^ qq[i-1]);
    return dd;
  endfunction

  task automatic step(input bit r, input bit de_i, input logic [1:0] c, input logic [7:0] d,
                      input bit dir_en = 1'b0, input logic [9:0] dir_val = 10'h000);
    item_t it;
    logic  cnt_ok;
    @(negedge clk_pix);
    rst_pix = r;
    de      = de_i;
    ctrl    = c;
    data    = d;
    if (r) begin
      mcnt = 0;
      q.delete();
      for (int i = 0; i < LAT; i++) begin
        it = '{sym: 10'h354, is_data: 1'b0, d: 8'h00, dir_en: 1'b0, dir: 10'h000};
        q.push_back(it);
      end
    end else begin
      it.is_data = de_i;
      it.d       = d;
      it.dir_en  = dir_en;
      it.dir     = dir_val;
      model_enc(de_i, c, d, it.sym);
      q.push_back(it);
    end
    @(posedge clk_pix);
    #1;
    if (r) begin
      chk("reset_sym", 32'(tmds), 32'h354);
      chk("reset_cnt", 32'(dut.cnt), 32'h0);
    end else begin
      it = q.pop_front();
      chk("sym", 32'(tmds), 32'(it.sym));
      if (it.is_data) chk("decode", 32'(decode(tmds)), 32'(it.d));
      if (it.dir_en) chk("directed", 32'(tmds), 32'(it.dir));
      cnt_ok = ($signed(dut.cnt) >= -10) && ($signed(dut.cnt) <= 10);
      chk("cnt_range", 32'(cnt_ok), 32'h1);
    end
  endtask

  task automatic blank(input int n, input logic [1:0] c);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, c, 8'bxxxxxxxx, 1'b1, 10'h000 | (c == 2'b00 ? 10'h354 :
                                                                          c == 2'b01 ? 10'h0AB :
                                                                          c == 2'b10 ? 10'h154 : 10'h2AB));
  endtask

  initial begin
    // Reset and control codes
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b00, 8'h00);
    blank(5, 2'b00);
    blank(4, 2'b01);
    blank(4, 2'b10);
    blank(4, 2'b11);
    blank(4, 2'b00);

    // Three zero bytes: Case A, then B, then C
    step(1'b0, 1'b1, 2'b00, 8'h00, 1'b1, 10'h100);
    step(1'b0, 1'b1, 2'b00, 8'h00, 1'b1, 10'h3FF);
    step(1'b0, 1'b1, 2'b00, 8'h00, 1'b1, 10'h100);
    blank(4, 2'b00);

    // 0xFF takes the XNOR path
    step(1'b0, 1'b1, 2'b00, 8'hFF, 1'b1, 10'h200);
    blank(4, 2'b00);

    // Randomized lines with blanking
    for (int ln = 0; ln < 16; ln++) begin
      for (int p = 0; p < 640; p++) step(1'b0, 1'b1, 2'b00, 8'($urandom));
      for (int b = 0; b < 160; b++) step(1'b0, 1'b0, 2'($urandom), 8'bxxxxxxxx);
    end

    // Reset pulse mid-line, then a fresh start
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 2'b00, 8'($urandom));
    step(1'b1, 1'b1, 2'b00, 8'h5A);
    blank(3, 2'b00);
    step(1'b0, 1'b1, 2'b00, 8'h00, 1'b1, 10'h100);
    step(1'b0, 1'b1, 2'b00, 8'h00, 1'b1, 10'h3FF);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 2'b00, 8'($urandom));

    // Single-cycle gap restarts balance
    step(1'b0, 1'b1, 2'b00, 8'h00);
    step(1'b0, 1'b0, 2'b10, 8'bxxxxxxxx, 1'b1, 10'h154);
    step(1'b0, 1'b1, 2'b00, 8'h00, 1'b1, 10'h100);
    step(1'b0, 1'b1, 2'b00, 8'h00, 1'b1, 10'h3FF);
    blank(LAT + 2, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
